output_flit_sender: RTL and testbench
=====================================

# output_flit_sender

Transmit-side link stage at each router output port, feeding the downstream router's input buffers over the on/off flow-controlled link. It accepts flits from switch traversal into per-VC skid FIFOs and checks packet framing per VC. It picks one eligible VC per cycle round-robin, gated by the per-VC on_off signal returned by the downstream input buffer, and drives a registered flit onto the link.

## Interface
- VC_NUM, default VC_NUM from noc_params: virtual channels on the link.
- SKID_DEPTH, default 2: per-VC FIFO depth, ≥2, covering on/off round-trip latency.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flit_i  input  flit_t  flit from crossbar; flit_i.vc_id is the downstream VC.
- valid_i  input  1  flit_i valid this cycle.
- ready_o  output  VC_NUM  per-VC space available (FIFO not full).
- on_off_i  input  VC_NUM  downstream input buffer of VC v can accept (1 = on).
- flit_o  output  flit_t  registered link flit.
- valid_o  output  1  flit_o valid.
- vc_busy_o  output  VC_NUM  packet in progress on VC v (head accepted, tail not yet sent).
- proto_err_o  output  1  one-cycle pulse: framing violation or write to full VC.

## Operation
- Write: valid_i && ready_o[flit_i.vc_id] && framing legal → push into FIFO[vc_id].
- Framing FSM per VC, input side, states IDLE/OPEN, reset IDLE:
  - IDLE: HEAD → OPEN; HEADTAIL stays IDLE; BODY/TAIL is illegal.
  - OPEN: BODY stays OPEN; TAIL → IDLE; HEAD/HEADTAIL is illegal.
- Illegal flit or write to full VC: flit dropped, FSM unchanged, proto_err_o = 1 next cycle.
- Eligible VC v: FIFO[v] non-empty && on_off_i[v] == 1.
- Round-robin arbiter: pointer starts at VC 0. Search begins at pointer; pointer moves to winner+1 (mod VC_NUM) only when a grant occurs.
- Grant: pop FIFO[winner]; flit_o <= popped flit, vc_id unchanged; valid_o <= 1. No grant: valid_o <= 0, flit_o holds its last value.
- vc_busy_o[v]: set when HEAD is pushed into v; cleared when TAIL of v is popped onto the link. HEADTAIL never sets it.
- ready_o[v] = count[v] < SKID_DEPTH, from registered count only. A full FIFO refuses a write even if it pops the same cycle.
- Count width $clog2(SKID_DEPTH+1). Read/write pointers wrap modulo SKID_DEPTH.

## Timing
- Reset: valid_o 0, flit_o 0, ready_o all 1, vc_busy_o 0, proto_err_o 0, FIFOs empty, FSMs IDLE, RR pointer 0.
- Latency: flit written at edge N is visible on flit_o/valid_o after edge N+1 at the earliest (empty FIFO, on_off high).
- Throughput: one flit per cycle aggregate, and one per cycle on a single VC with on_off held high.
- on_off_i is sampled in the grant cycle. A flit already in flit_o is not recalled when on_off drops; SKID_DEPTH and downstream slack absorb this.
- Same cycle push and pop on one VC: count unchanged, order preserved. Push to an empty VC can win only from the next cycle (no bypass).
- Reset mid-packet: all state cleared immediately, including in-flight FIFO contents.

## Structure
- Use flit_t, flit_label_t and VC_SIZE from noc_params. Add to noc_params: a sender_vc_state_t enum (IDLE, OPEN).
- Sub-module vc_skid_fifo (parameter DEPTH; push, pop, data, count, empty, full), instantiated VC_NUM times. The arbiter and FSMs live in the top level.

## Test plan
- Single packet, VC 0: HEAD, BODY, TAIL in consecutive cycles, on_off = 2'b11 → flit_o shows the same three flits at cycles 1-3 after each write, vc_busy_o[0] high from the cycle after HEAD until the cycle after TAIL exits.
- Backpressure: on_off_i[1] = 0, three writes to VC 1 (SKID_DEPTH 2) → first two accepted, ready_o[1] = 0, third gives proto_err_o pulse, valid_o stays 0. Raise on_off → two flits sent on consecutive cycles.
- Round-robin: both VCs hold 2 flits, on_off = 2'b11 → output VC order 0,1,0,1.
- Framing: BODY to idle VC 0 → dropped, proto_err_o pulses. HEAD then HEAD on VC 1 → second HEAD dropped, error pulses.
- HEADTAIL on VC 1 → sent after 1 cycle, vc_busy_o[1] never asserted.
- Reset asserted asynchronously between HEAD and TAIL → outputs return to reset values immediately. A new HEAD after deassertion is accepted.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC link types: flit format, flit labels, VC sizing and the
// per-VC framing state used by the output flit sender.
// Also holds the framing rules as helpers so every user applies the same packet grammar.
package noc_params;

  // Virtual channels per physical link.
  localparam int VC_NUM    = 2;
  // Width of a VC index. It is kept at least 1 bit so a single-VC link still has a field.
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  // Payload bits carried per flit.
  localparam int DATA_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [VC_SIZE-1:0]     vc_id;
    logic [DATA_SIZE-1:0]   data;
  } flit_t;

  // Input-side packet framing state of one VC.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } sender_vc_state_t;

  // A VC with no open packet may only start one (HEAD or HEADTAIL).
  // An open packet may only continue or close (BODY or TAIL).
  function automatic logic framing_legal(sender_vc_state_t st, flit_label_t lab);
    logic ok;
    if (st == IDLE) ok = (lab == HEAD) || (lab == HEADTAIL);
    else            ok = (lab == BODY) || (lab == TAIL);
    return ok;
  endfunction

  // Next framing state after a legal flit has been accepted.
  function automatic sender_vc_state_t framing_next(sender_vc_state_t st, flit_label_t lab);
    sender_vc_state_t nxt;
    case (lab)
      HEAD:    nxt = OPEN;
      TAIL:    nxt = IDLE;
      default: nxt = st;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vc_skid_fifo.sv
// Purpose: per-VC skid FIFO holding flits until the link arbiter takes them.
// Latency: a pushed flit is readable on rd_data the cycle after the push, with no bypass.
// Backpressure: a push to a full FIFO is ignored, so the caller gates pushes with full.
// Ports: clk/rst (async, active-high), push/wr_data, pop/rd_data, count, empty, full.
module vc_skid_fifo
  import noc_params::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  flit_t                      wr_data,
  input  logic                       pop,
  output flit_t                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flit_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which does not need to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage needs no reset. Clearing the pointers and the count makes it empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/output_flit_sender.sv
// Purpose: router output-port link stage. It checks framing per VC, uses a per-VC skid FIFO
//   and round-robins one eligible VC per cycle onto a registered link flit.
// Latency: 1 cycle from the FIFO write edge to flit_o/valid_o at the earliest.
// Backpressure: ready_o per VC (FIFO not full). on_off_i gates the grant per VC.
//   Refused or ill-framed writes are dropped and flagged on proto_err_o.
// Ports: clk, rst (async, active-high); flit_i/valid_i/ready_o from the crossbar;
//   on_off_i from the downstream buffer; flit_o/valid_o on the link; vc_busy_o; proto_err_o.
module output_flit_sender #(
  parameter int VC_NUM     = noc_params::VC_NUM,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  noc_params::flit_t     flit_i,
  input  logic                  valid_i,
  output logic [VC_NUM-1:0]     ready_o,
  input  logic [VC_NUM-1:0]     on_off_i,
  output noc_params::flit_t     flit_o,
  output logic                  valid_o,
  output logic [VC_NUM-1:0]     vc_busy_o,
  output logic                  proto_err_o
);

  import noc_params::*;

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic [CNT_W-1:0]  fifo_count [VC_NUM];
  flit_t             fifo_rd    [VC_NUM];
  logic [VC_NUM-1:0] fifo_empty;
  logic [VC_NUM-1:0] fifo_full;
  logic [VC_NUM-1:0] push;
  logic [VC_NUM-1:0] pop;
  logic [VC_NUM-1:0] eligible;
  logic [VC_NUM-1:0] busy_next;

  sender_vc_state_t   vc_state [VC_NUM];
  logic [VC_SIZE-1:0] rr_ptr;
  logic [VC_SIZE-1:0] winner;
  logic               grant;
  logic               wr_err;
  logic               wr_in_range;

  // The VC field can encode more values than VC_NUM when VC_NUM is not a power of two.
  assign wr_in_range = (int'(flit_i.vc_id) < VC_NUM);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_skid_fifo #(
      .DEPTH (SKID_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[v]),
      .wr_data (flit_i),
      .pop     (pop[v]),
      .rd_data (fifo_rd[v]),
      .count   (fifo_count[v]),
      .empty   (fifo_empty[v]),
      .full    (fifo_full[v])
    );

    // Ready comes from the registered count only, so a full VC refuses a write
    // even in a cycle where it also pops.
    assign ready_o[v]  = (fifo_count[v] < CNT_W'(SKID_DEPTH));
    assign eligible[v] = !fifo_empty[v] && on_off_i[v];
    assign pop[v]      = grant && (winner == VC_SIZE'(v));

    // The write decode must never push into a full FIFO.
    a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push[v] && fifo_full[v]));
  end

  // Write decode. At most one VC is pushed per cycle.
  // A refused or ill-framed flit is dropped, and the framing state is left unchanged.
  always_comb begin
    push   = '0;
    wr_err = 1'b0;
    if (valid_i) begin
      if (wr_in_range && ready_o[flit_i.vc_id] &&
          framing_legal(vc_state[flit_i.vc_id], flit_i.flit_label)) begin
        push[flit_i.vc_id] = 1'b1;
      end else begin
        wr_err = 1'b1;
      end
    end
  end

  // Round-robin arbiter. The search starts at rr_ptr, and the first eligible VC wins.
  always_comb begin
    int idx;
    grant  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_ptr) + i) % VC_NUM;
      if (!grant && eligible[idx[VC_SIZE-1:0]]) begin
        grant  = 1'b1;
        winner = VC_SIZE'(idx);
      end
    end
  end

  // A VC is busy from the HEAD push until its TAIL leaves on the link.
  // If a TAIL leaves and a new HEAD enters the same VC in one cycle, the set wins.
  always_comb begin
    busy_next = vc_busy_o;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop[v] && (fifo_rd[v].flit_label == TAIL)) busy_next[v] = 1'b0;
      if (push[v] && (flit_i.flit_label == HEAD))    busy_next[v] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_o      <= '0;
      valid_o     <= 1'b0;
      rr_ptr      <= '0;
      proto_err_o <= 1'b0;
      vc_busy_o   <= '0;
      for (int v = 0; v < VC_NUM; v++) vc_state[v] <= IDLE;
    end else begin
      proto_err_o <= wr_err;
      valid_o     <= grant;
      vc_busy_o   <= busy_next;
      // With no grant, flit_o keeps its last value, and only valid_o drops.
      if (grant) begin
        flit_o <= fifo_rd[winner];
        rr_ptr <= (winner == VC_SIZE'(VC_NUM - 1)) ? '0 : winner + 1'b1;
      end
      for (int v = 0; v < VC_NUM; v++) begin
        if (push[v]) vc_state[v] <= framing_next(vc_state[v], flit_i.flit_label);
      end
    end
  end

endmodule

// File: tb/tb_output_flit_sender.sv
module tb_output_flit_sender;
  import noc_params::*;

  localparam int SKID = 2;

  logic              clk;
  logic              rst;
  flit_t             flit_i;
  logic              valid_i;
  logic [VC_NUM-1:0] ready_o;
  logic [VC_NUM-1:0] on_off_i;
  flit_t             flit_o;
  logic              valid_o;
  logic [VC_NUM-1:0] vc_busy_o;
  logic              proto_err_o;

  output_flit_sender #(.VC_NUM(VC_NUM), .SKID_DEPTH(SKID)) dut (
    .clk         (clk),
    .rst         (rst),
    .flit_i      (flit_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .on_off_i    (on_off_i),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .vc_busy_o   (vc_busy_o),
    .proto_err_o (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: per-VC queues of flits, an open-packet flag per VC and a rotating priority.
  flit_t             mq [VC_NUM][$];
  bit                mopen [VC_NUM];
  logic [VC_NUM-1:0] mbusy;
  int                mrr;
  flit_t             mflit;
  bit                mvld;
  bit                merr;

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      mq[v].delete();
      mopen[v] = 0;
    end
    mbusy = '0; mrr = 0; mflit = '0; mvld = 0; merr = 0;
  endtask

  function automatic logic [VC_NUM-1:0] model_ready();
    logic [VC_NUM-1:0] r;
    for (int v = 0; v < VC_NUM; v++) r[v] = (mq[v].size() < SKID);
    return r;
  endfunction

  task automatic model_step(bit v, flit_t f, logic [VC_NUM-1:0] oo);
    bit g, full, legal;
    int w, vc;
    flit_t pf;
    g = 0; w = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      int c;
      c = (mrr + i) % VC_NUM;
      if (!g && mq[c].size() > 0 && oo[c]) begin g = 1; w = c; end
    end
    vc    = int'(f.vc_id);
    full  = mq[vc].size() >= SKID;
    legal = mopen[vc] ? (f.flit_label == BODY || f.flit_label == TAIL)
                      : (f.flit_label == HEAD || f.flit_label == HEADTAIL);
    merr = 0;
    mvld = g;
    if (g) begin
      pf    = mq[w].pop_front();
      mflit = pf;
      mrr   = (w + 1) % VC_NUM;
      if (pf.flit_label == TAIL) mbusy[w] = 1'b0;
    end
    if (v) begin
      if (full || !legal) merr = 1;
      else begin
        mq[vc].push_back(f);
        if (f.flit_label == HEAD) begin mopen[vc] = 1; mbusy[vc] = 1'b1; end
        else if (f.flit_label == TAIL) mopen[vc] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid_o", 32'(valid_o), 32'(mvld));
    chk("flit_o", 32'(flit_o), 32'(mflit));
    chk("vc_busy_o", 32'(vc_busy_o), 32'(mbusy));
    chk("proto_err_o", 32'(proto_err_o), 32'(merr));
    chk("ready_o", 32'(ready_o), 32'(model_ready()));
  endtask

  // One clock cycle: drive the inputs, check ready before the edge, advance the model, check after the edge.
  task automatic cycle(bit v, flit_t f, logic [VC_NUM-1:0] oo);
    valid_i  = v;
    flit_i   = f;
    on_off_i = oo;
    #1;
    chk("ready_pre", 32'(ready_o), 32'(model_ready()));
    model_step(v, f, oo);
    @(posedge clk); #1;
    compare_all();
  endtask

  function automatic flit_t mkf(flit_label_t l, int vc, logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.data       = d;
    return f;
  endfunction

  typedef struct {
    bit          v;
    flit_label_t lab;
    int          vc;
    logic [15:0] d;
    logic [1:0]  oo;
    bit          e_vld;
    logic [15:0] e_dat;
    bit          e_err;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    flit_t f;
    rst = 1'b0; valid_i = 1'b0; flit_i = '0; on_off_i = '0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_flit", 32'(flit_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'b11);
    chk("rst_busy", 32'(vc_busy_o), 32'd0);
    chk("rst_err", 32'(proto_err_o), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Directed vectors: single packet on VC 0, framing errors, HEADTAIL on VC 1.
    tbl[0]  = '{1, HEAD,     0, 16'h00A1, 2'b11, 0, 16'h0000, 0, 2'b01};
    tbl[1]  = '{1, BODY,     0, 16'h00A2, 2'b11, 1, 16'h00A1, 0, 2'b01};
    tbl[2]  = '{1, TAIL,     0, 16'h00A3, 2'b11, 1, 16'h00A2, 0, 2'b01};
    tbl[3]  = '{0, BODY,     0, 16'h0000, 2'b11, 1, 16'h00A3, 0, 2'b00};
    tbl[4]  = '{0, BODY,     0, 16'h0000, 2'b11, 0, 16'h00A3, 0, 2'b00};
    tbl[5]  = '{1, BODY,     0, 16'h00B1, 2'b11, 0, 16'h00A3, 1, 2'b00};
    tbl[6]  = '{1, HEAD,     1, 16'h00B2, 2'b11, 0, 16'h00A3, 0, 2'b10};
    tbl[7]  = '{1, HEAD,     1, 16'h00B3, 2'b11, 1, 16'h00B2, 1, 2'b10};
    tbl[8]  = '{1, TAIL,     1, 16'h00B4, 2'b11, 0, 16'h00B2, 0, 2'b10};
    tbl[9]  = '{0, BODY,     0, 16'h0000, 2'b11, 1, 16'h00B4, 0, 2'b00};
    tbl[10] = '{1, HEADTAIL, 1, 16'h00C1, 2'b11, 0, 16'h00B4, 0, 2'b00};
    tbl[11] = '{0, BODY,     0, 16'h0000, 2'b11, 1, 16'h00C1, 0, 2'b00};
    tbl[12] = '{0, BODY,     0, 16'h0000, 2'b11, 0, 16'h00C1, 0, 2'b00};
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, mkf(tbl[i].lab, tbl[i].vc, tbl[i].d), tbl[i].oo);
      chk($sformatf("tbl%0d_vld", i), 32'(valid_o), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_dat", i), 32'(flit_o.data), 32'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_err", i), 32'(proto_err_o), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 32'(vc_busy_o), 32'(tbl[i].e_busy));
    end

    // Backpressure on VC 1: two flits fit, and the third is refused.
    cycle(1, mkf(HEAD, 1, 16'h00D1), 2'b01);
    cycle(1, mkf(BODY, 1, 16'h00D2), 2'b01);
    chk("bp_ready1", 32'(ready_o[1]), 32'd0);
    cycle(1, mkf(BODY, 1, 16'h00D3), 2'b01);
    chk("bp_err", 32'(proto_err_o), 32'd1);
    chk("bp_vld_off", 32'(valid_o), 32'd0);
    cycle(0, mkf(BODY, 1, 16'h0000), 2'b11);
    chk("bp_out1", {valid_o, 15'd0, flit_o.data}, {1'b1, 15'd0, 16'h00D1});
    cycle(1, mkf(TAIL, 1, 16'h00D4), 2'b11);
    chk("bp_out2", {valid_o, 15'd0, flit_o.data}, {1'b1, 15'd0, 16'h00D2});
    cycle(0, mkf(BODY, 1, 16'h0000), 2'b11);
    cycle(0, mkf(BODY, 1, 16'h0000), 2'b11);

    // Round-robin: both VCs hold two flits, and the output alternates starting at VC 0.
    cycle(1, mkf(HEAD, 0, 16'h00E1), 2'b00);
    cycle(1, mkf(HEAD, 1, 16'h00F1), 2'b00);
    cycle(1, mkf(TAIL, 0, 16'h00E2), 2'b00);
    cycle(1, mkf(TAIL, 1, 16'h00F2), 2'b00);
    for (int i = 0; i < 4; i++) begin
      cycle(0, mkf(BODY, 0, 16'h0000), 2'b11);
      chk($sformatf("rr_vc%0d", i), {valid_o, 31'(flit_o.vc_id)}, {1'b1, 31'(i % 2)});
    end
    cycle(0, mkf(BODY, 0, 16'h0000), 2'b11);

    // Asynchronous reset in the middle of a packet.
    cycle(1, mkf(HEAD, 0, 16'h0061), 2'b11);
    cycle(1, mkf(BODY, 0, 16'h0062), 2'b11);
    valid_i = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_flit", 32'(flit_o), 32'd0);
    chk("mrst_busy", 32'(vc_busy_o), 32'd0);
    chk("mrst_ready", 32'(ready_o), 32'b11);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    cycle(1, mkf(HEAD, 0, 16'h0063), 2'b11);
    chk("mrst_head_ok", {proto_err_o, 31'(vc_busy_o)}, {1'b0, 31'b01});
    cycle(1, mkf(TAIL, 0, 16'h0064), 2'b11);
    cycle(0, mkf(BODY, 0, 16'h0000), 2'b11);
    cycle(0, mkf(BODY, 0, 16'h0000), 2'b11);

    // Random traffic against the model. The labels are mostly legal, and on_off is biased towards on.
    for (int n = 0; n < 400; n++) begin
      int vc;
      flit_label_t lab;
      logic [VC_NUM-1:0] oo;
      vc = $urandom_range(0, VC_NUM - 1);
      if ($urandom_range(0, 7) == 0) lab = flit_label_t'($urandom_range(0, 3));
      else if (mopen[vc]) lab = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
      else lab = ($urandom_range(0, 1) == 0) ? HEAD : HEADTAIL;
      for (int v = 0; v < VC_NUM; v++) oo[v] = ($urandom_range(0, 3) != 0);
      f = mkf(lab, vc, 16'($urandom));
      cycle($urandom_range(0, 3) != 0, f, oo);
    end
    for (int n = 0; n < 6; n++) cycle(0, mkf(BODY, 0, 16'h0000), 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
